// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit core: result-dump FSM encoding, word geometry, result region base.
// Pure declarations, no logic.
package cpu24_pkg;

    localparam int          WORD_W         = 24;
    localparam int          BYTES_PER_WORD = 3;
    // Also the store-notifier threshold on the CPU side; keep the two in step.
    localparam logic [13:0] RESULT_BASE    = 14'h3000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LAT  = 3'd2,
        ST_B2   = 3'd3,
        ST_B1   = 3'd4,
        ST_B0   = 3'd5,
        ST_CSUM = 3'd6,
        ST_DONE = 3'd7
    } dump_state_t;

    // Byte idx of a 24-bit word, 2 = most significant.
    function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

endpackage

// File: rtl/word_serializer_24to8.sv
// Splits a loaded 24-bit word into 3 bytes MSB-first and keeps the running XOR of every byte sent.
// Latency: first byte valid the cycle after load; one byte per handshake thereafter.
// Backpressure: holds tx_data/tx_valid until tx_ready; after the final word it appends the checksum byte.
module word_serializer_24to8
    import cpu24_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              final_word,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              last_byte,
    output logic              csum_sent
);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        byte_sel;
    logic              csum_mode;
    logic [7:0]        csum;
    logic              hs;

    assign hs        = tx_valid & tx_ready;
    assign last_byte = hs & ~csum_mode & (byte_sel == 2'd0);
    assign csum_sent = hs & csum_mode;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q    <= '0;
            byte_sel  <= '0;
            csum_mode <= 1'b0;
            csum      <= 8'h00;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
        end else if (load) begin
            word_q    <= load_word;
            byte_sel  <= 2'(BYTES_PER_WORD - 1);
            csum_mode <= 1'b0;
            tx_data   <= word_byte(load_word, 2'(BYTES_PER_WORD - 1));
            tx_valid  <= 1'b1;
        end else if (hs) begin
            if (csum_mode) begin
                csum_mode <= 1'b0;
                tx_valid  <= 1'b0;
            end else begin
                csum <= csum ^ tx_data;
                if (byte_sel != 2'd0) begin
                    byte_sel <= byte_sel - 2'd1;
                    tx_data  <= word_byte(word_q, byte_sel - 2'd1);
                end else if (final_word) begin
                    // Checksum goes out back-to-back with the last data byte, folding that byte in.
                    csum_mode <= 1'b1;
                    tx_data   <= csum ^ tx_data;
                end else begin
                    tx_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dmem_result_reader.sv
// Dumps WORD_COUNT data-RAM words from BASE_ADDR as a byte stream plus XOR checksum once the core halts.
// Latency: 5 cycles per word with tx_ready high (RD, LAT, 3 bytes); 5*WORD_COUNT+1 cycles to DONE.
// Backpressure: valid/ready on tx; bytes are held stable while stalled, RAM is only read between words.
module dmem_result_reader
    import cpu24_pkg::*;
#(
    parameter int                 DATA_AW    = 14,
    parameter logic [DATA_AW-1:0] BASE_ADDR  = RESULT_BASE,
    parameter int                 WORD_COUNT = 16,
    parameter int                 DataR      = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    output logic [DATA_AW-1:0] mem_addr,
    output logic               mem_rd_en,
    input  logic [DataR-1:0]   mem_rd_data,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               done,
    output logic [DATA_AW:0]   word_idx
);

    localparam logic [DATA_AW:0] LAST_IDX = (DATA_AW+1)'(WORD_COUNT - 1);

    dump_state_t state_q;
    dump_state_t state_d;
    logic        start;
    logic        is_last;
    logic        hs;
    logic        last_byte;
    logic        csum_sent;

    assign start   = (state_q == ST_IDLE) && halt;
    assign is_last = (word_idx == LAST_IDX);
    assign hs      = tx_valid & tx_ready;

    // Address wraps modulo 2^DATA_AW through the natural truncation of the add.
    assign mem_rd_en = (state_q == ST_RD);
    assign mem_addr  = mem_rd_en ? (BASE_ADDR + word_idx[DATA_AW-1:0]) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (halt)      state_d = ST_RD;
            ST_RD:                  state_d = ST_LAT;
            ST_LAT:                 state_d = ST_B2;
            ST_B2:   if (hs)        state_d = ST_B1;
            ST_B1:   if (hs)        state_d = ST_B0;
            ST_B0:   if (last_byte) state_d = is_last ? ST_CSUM : ST_RD;
            ST_CSUM: if (csum_sent) state_d = ST_DONE;
            ST_DONE: if (!halt)     state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            word_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                word_idx <= '0;
                busy     <= 1'b1;
            end
            if ((state_q == ST_B0) && last_byte && !is_last) begin
                word_idx <= word_idx + 1'b1;
            end
            if ((state_q == ST_CSUM) && csum_sent) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if ((state_q == ST_DONE) && !halt) begin
                done <= 1'b0;
            end
        end
    end

    word_serializer_24to8 u_ser (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .load       (state_q == ST_LAT),
        .load_word  (WORD_W'(mem_rd_data)),
        .final_word (is_last),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .last_byte  (last_byte),
        .csum_sent  (csum_sent)
    );

endmodule

// File: tb/tb_dmem_result_reader.sv
// Three readers: 16 words at 0x3000, 1 word at 0x3000, 2 words wrapping from 0x3FFF.
// Inputs change and outputs are sampled on the falling edge.
module tb_dmem_result_reader;

    logic        clk;
    logic        rst      [3];
    logic        halt     [3];
    logic        rdy      [3];
    logic        rand_rdy [3];
    logic [13:0] addr     [3];
    logic        en       [3];
    logic [23:0] rdd      [3];
    logic [7:0]  txd      [3];
    logic        tx_valid [3];
    logic        busy     [3];
    logic        done     [3];
    logic [14:0] widx     [3];

    logic [23:0] mem0 [0:16383];
    logic [23:0] memb [0:16383];

    logic [7:0]  cap0[$], cap1[$], cap2[$];
    logic [7:0]  exp_q[$];
    logic [13:0] alog[$];
    logic        stall_prev [3];
    logic [7:0]  stall_dat  [3];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en[0]) rdd[0] <= mem0[addr[0]];
        if (en[1]) rdd[1] <= memb[addr[1]];
        if (en[2]) rdd[2] <= memb[addr[2]];
    end

    dmem_result_reader #(.DATA_AW(14), .BASE_ADDR(14'h3000), .WORD_COUNT(16), .DataR(24)) u0 (
        .clk(clk), .rst(rst[0]), .halt(halt[0]), .mem_addr(addr[0]), .mem_rd_en(en[0]),
        .mem_rd_data(rdd[0]), .tx_data(txd[0]), .tx_valid(tx_valid[0]), .tx_ready(rdy[0]),
        .busy(busy[0]), .done(done[0]), .word_idx(widx[0]));

    dmem_result_reader #(.DATA_AW(14), .BASE_ADDR(14'h3000), .WORD_COUNT(1), .DataR(24)) u1 (
        .clk(clk), .rst(rst[1]), .halt(halt[1]), .mem_addr(addr[1]), .mem_rd_en(en[1]),
        .mem_rd_data(rdd[1]), .tx_data(txd[1]), .tx_valid(tx_valid[1]), .tx_ready(rdy[1]),
        .busy(busy[1]), .done(done[1]), .word_idx(widx[1]));

    dmem_result_reader #(.DATA_AW(14), .BASE_ADDR(14'h3FFF), .WORD_COUNT(2), .DataR(24)) u2 (
        .clk(clk), .rst(rst[2]), .halt(halt[2]), .mem_addr(addr[2]), .mem_rd_en(en[2]),
        .mem_rd_data(rdd[2]), .tx_data(txd[2]), .tx_valid(tx_valid[2]), .tx_ready(rdy[2]),
        .busy(busy[2]), .done(done[2]), .word_idx(widx[2]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Records what the coming rising edge will see, then advances one cycle.
    task automatic tick();
        for (int i = 0; i < 3; i++) begin
            if (rand_rdy[i]) rdy[i] = ($urandom_range(0, 99) < 30);
            if (rst[i]) begin
                stall_prev[i] = 1'b0;
            end else begin
                if (stall_prev[i])
                    check($sformatf("stall_hold_u%0d", i), {23'd0, tx_valid[i], txd[i]}, {23'd0, 1'b1, stall_dat[i]});
                if (tx_valid[i] && rdy[i]) begin
                    case (i)
                        0:       cap0.push_back(txd[i]);
                        1:       cap1.push_back(txd[i]);
                        default: cap2.push_back(txd[i]);
                    endcase
                end
                stall_prev[i] = tx_valid[i] && !rdy[i];
                stall_dat[i]  = txd[i];
            end
        end
        if (en[2] && !rst[2]) alog.push_back(addr[2]);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected stream: each word MSB-first from a wrapped window, then XOR of all data bytes.
    function automatic void model(input int which, input int base, input int count);
        logic [7:0]  x;
        logic [23:0] w;
        exp_q.delete();
        x = 8'h00;
        for (int k = 0; k < count; k++) begin
            w = (which == 0) ? mem0[(base + k) % 16384] : memb[(base + k) % 16384];
            for (int b = 2; b >= 0; b--) begin
                exp_q.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
        exp_q.push_back(x);
    endfunction

    task automatic cmp_stream(input string nm, input int i);
        logic [7:0] got[$];
        case (i)
            0:       got = cap0;
            1:       got = cap1;
            default: got = cap2;
        endcase
        check({nm, "_len"}, got.size(), exp_q.size());
        for (int k = 0; k < got.size() && k < exp_q.size(); k++)
            check($sformatf("%s_byte%0d", nm, k), {24'd0, got[k]}, {24'd0, exp_q[k]});
    endtask

    task automatic run_dump(input int i, input int budget, output int cyc);
        cyc = 0;
        halt[i] = 1'b1;
        while (!done[i] && cyc < budget) begin
            tick();
            cyc++;
        end
        check($sformatf("done_reached_u%0d", i), {31'd0, done[i]}, 32'd1);
    endtask

    function automatic void clear_caps();
        cap0.delete();
        cap1.delete();
        cap2.delete();
    endfunction

    typedef struct {
        logic       h;
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       b;
        logic       dn;
        logic       en;
    } vec_t;

    vec_t tbl[10];
    int   cyc;

    initial begin
        // One-word dump of A55A3C with a stall on B2 and on the checksum, halt dropped mid-dump.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        for (int a = 0; a < 16384; a++) begin
            mem0[a] = 24'h0;
            memb[a] = 24'h0;
        end
        for (int w = 0; w < 16; w++) mem0[14'h3000 + w] = 24'(w + 1);
        memb[14'h3000] = 24'hA55A3C;
        memb[14'h3FFF] = 24'h123456;
        memb[14'h0000] = 24'hABCDEF;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; halt[i] = 1'b0; rdy[i] = 1'b1; rand_rdy[i] = 1'b0; stall_prev[i] = 1'b0;
        end
        @(negedge clk);
        tick();
        tick();
        check("rst_tx_valid", {31'd0, tx_valid[0]}, 32'd0);
        check("rst_tx_data",  {24'd0, txd[0]}, 32'd0);
        check("rst_busy",     {31'd0, busy[0]}, 32'd0);
        check("rst_done",     {31'd0, done[0]}, 32'd0);
        check("rst_word_idx", {17'd0, widx[0]}, 32'd0);
        check("rst_rd_en",    {31'd0, en[0]}, 32'd0);
        check("rst_addr",     {18'd0, addr[0]}, 32'd0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        tick();

        // Full-rate dump, done latency measured from the halt-sampling edge.
        clear_caps();
        halt[0] = 1'b1;
        tick();
        check("first_busy",  {31'd0, busy[0]}, 32'd1);
        check("first_rd_en", {31'd0, en[0]}, 32'd1);
        check("first_addr",  {18'd0, addr[0]}, 32'h3000);
        cyc = 1;
        while (!done[0] && cyc < 400) begin
            tick();
            cyc++;
        end
        check("done_latency", cyc - 1, 32'd81);
        check("done_busy_low", {31'd0, busy[0]}, 32'd0);
        model(0, 'h3000, 16);
        cmp_stream("full_rate", 0);

        // Rearm, then a second dump under random backpressure.
        halt[0] = 1'b0;
        tick();
        tick();
        check("rearm_done_low", {31'd0, done[0]}, 32'd0);
        clear_caps();
        rand_rdy[0] = 1'b1;
        run_dump(0, 3000, cyc);
        rand_rdy[0] = 1'b0;
        rdy[0] = 1'b1;
        cmp_stream("backpressure", 0);

        // Halt held after done: nothing further goes out.
        clear_caps();
        repeat (20) tick();
        check("hold_no_bytes", cap0.size(), 32'd0);
        check("hold_done", {31'd0, done[0]}, 32'd1);
        check("hold_tx_valid", {31'd0, tx_valid[0]}, 32'd0);

        // Abort in B1 of word 1 (csum already nonzero), then restart from word 0.
        halt[0] = 1'b0;
        tick();
        clear_caps();
        halt[0] = 1'b1;
        repeat (9) tick();
        check("abort_pt_valid", {31'd0, tx_valid[0]}, 32'd1);
        check("abort_pt_bytes", cap0.size(), 32'd4);
        check("abort_pt_word_idx", {17'd0, widx[0]}, 32'd1);
        rdy[0] = 1'b0;
        tick();
        tick();
        rst[0] = 1'b1;
        tick();
        check("abort_tx_valid", {31'd0, tx_valid[0]}, 32'd0);
        check("abort_busy", {31'd0, busy[0]}, 32'd0);
        check("abort_done", {31'd0, done[0]}, 32'd0);
        check("abort_word_idx", {17'd0, widx[0]}, 32'd0);
        rst[0] = 1'b0;
        rdy[0] = 1'b1;
        clear_caps();
        run_dump(0, 400, cyc);
        model(0, 'h3000, 16);
        cmp_stream("restart", 0);

        // One-word checksum case, cycle by cycle.
        clear_caps();
        for (int k = 0; k < 10; k++) begin
            halt[1] = tbl[k].h;
            rdy[1]  = tbl[k].r;
            tick();
            check($sformatf("vec%0d_valid", k), {31'd0, tx_valid[1]}, {31'd0, tbl[k].v});
            if (tbl[k].v) check($sformatf("vec%0d_data", k), {24'd0, txd[1]}, {24'd0, tbl[k].d});
            check($sformatf("vec%0d_busy", k), {31'd0, busy[1]}, {31'd0, tbl[k].b});
            check($sformatf("vec%0d_done", k), {31'd0, done[1]}, {31'd0, tbl[k].dn});
            check($sformatf("vec%0d_rd_en", k), {31'd0, en[1]}, {31'd0, tbl[k].en});
        end
        model(1, 'h3000, 1);
        cmp_stream("one_word", 1);

        // Address wrap past the top of the RAM.
        clear_caps();
        alog.delete();
        rand_rdy[2] = 1'b1;
        run_dump(2, 1000, cyc);
        rand_rdy[2] = 1'b0;
        model(1, 'h3FFF, 2);
        cmp_stream("wrap", 2);
        check("wrap_reads", alog.size(), 32'd2);
        if (alog.size() == 2) begin
            check("wrap_addr0", {18'd0, alog[0]}, 32'h3FFF);
            check("wrap_addr1", {18'd0, alog[1]}, 32'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
